// File: rtl/cpu_pkg.sv
// Shared types and constants for the simple RISC CPU controller.
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int ADDR_W   = 5;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic isAluOp(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Eight-phase wrapping counter; hold_i freezes it in place (used for halt).
module phase_counter
  import cpu_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   hold_i,
  output phase_t phase_o
);

  phase_t phase_q;
  phase_t phase_d;

  always_comb begin
    phase_d = hold_i ? phase_q : phase_t'(phase_q + 3'd1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: decodes phase, opcode and zero flag into datapath strobes.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                zero_i,
  output logic                sel_o,
  output logic                rd_o,
  output logic                ld_ir_o,
  output logic                inc_pc_o,
  output logic                ld_pc_o,
  output logic                ld_ac_o,
  output logic                wr_o,
  output logic                data_e_o,
  output logic                halt_o,
  output logic [2:0]          phase_o
);

  phase_t  phase;
  opcode_t op;
  logic    aluOp;
  logic    haltHold;

  assign op       = opcode_t'(opcode_i);
  assign aluOp    = isAluOp(op);
  assign haltHold = (phase == OP_ADDR) && (op == HLT);

  phase_counter u_phase_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .hold_i  (haltHold),
    .phase_o (phase)
  );

  always_comb begin
    sel_o    = 1'b0;
    rd_o     = 1'b0;
    ld_ir_o  = 1'b0;
    inc_pc_o = 1'b0;
    ld_pc_o  = 1'b0;
    ld_ac_o  = 1'b0;
    wr_o     = 1'b0;
    data_e_o = 1'b0;
    halt_o   = 1'b0;
    case (phase)
      INST_ADDR: begin
        sel_o = 1'b1;
      end
      INST_FETCH: begin
        sel_o = 1'b1;
        rd_o  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel_o   = 1'b1;
        rd_o    = 1'b1;
        ld_ir_o = 1'b1;
      end
      OP_ADDR: begin
        inc_pc_o = (op != HLT);
        halt_o   = (op == HLT);
      end
      OP_FETCH: begin
        rd_o = aluOp;
      end
      ALU_OP: begin
        rd_o     = aluOp;
        inc_pc_o = (op == SKZ) && zero_i;
        ld_pc_o  = (op == JMP);
        data_e_o = (op == STO);
      end
      STORE: begin
        // JMP raises both ld and inc here; the PC resolves it with ld priority.
        rd_o     = aluOp;
        ld_ac_o  = aluOp;
        ld_pc_o  = (op == JMP);
        inc_pc_o = (op == JMP);
        wr_o     = (op == STO);
        data_e_o = (op == STO);
      end
      default: begin
        sel_o = 1'b0;
      end
    endcase
  end

  assign phase_o = phase;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed and random instructions against a behavioural model.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ldIr, incPc, ldPc, ldAc, wr, dataE, halt;
  logic [2:0] phase;
  logic [8:0] observed;

  int passCount  = 0;
  int checkCount = 0;
  int expPhase   = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .opcode_i (opcode),
    .zero_i   (zero),
    .sel_o    (sel),
    .rd_o     (rd),
    .ld_ir_o  (ldIr),
    .inc_pc_o (incPc),
    .ld_pc_o  (ldPc),
    .ld_ac_o  (ldAc),
    .wr_o     (wr),
    .data_e_o (dataE),
    .halt_o   (halt),
    .phase_o  (phase)
  );

  assign observed = {sel, rd, ldIr, incPc, ldPc, ldAc, wr, dataE, halt};

  // Strobe rules written per signal, as sets of phases and opcodes.
  function automatic logic [8:0] modelOut(input int ph, input int op, input bit z);
    bit isAlu;
    bit eSel, eRd, eLdIr, eInc, eLdPc, eLdAc, eWr, eDataE, eHalt;
    isAlu  = (op >= 2) && (op <= 5);
    eSel   = (ph <= 3);
    eRd    = (ph >= 1 && ph <= 3) || (ph >= 5 && isAlu);
    eLdIr  = (ph == 2) || (ph == 3);
    eInc   = (ph == 4 && op != 0) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    eLdPc  = (ph == 6 || ph == 7) && (op == 7);
    eLdAc  = (ph == 7) && isAlu;
    eWr    = (ph == 7) && (op == 6);
    eDataE = (ph >= 6) && (op == 6);
    eHalt  = (ph == 4) && (op == 0);
    return {eSel, eRd, eLdIr, eInc, eLdPc, eLdAc, eWr, eDataE, eHalt};
  endfunction

  task automatic applyStimulus(input int op, input int z);
    opcode = op[2:0];
    zero   = z[0];
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [8:0] expected;
    logic [2:0] expPh;
    expected = modelOut(expPhase, int'(opcode), zero);
    expPh    = expPhase[2:0];
    checkCount++;
    assert (phase === expPh) passCount++;
    else $error("[TB] FAIL %s.phase: observed %0d expected %0d", tag, phase, expPh);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s.strobes(ph%0d op%0d): observed %b expected %b", tag, expPh, opcode, observed, expected);
    checkCount++;
    assert ((rd & wr) === 1'b0) passCount++;
    else $error("[TB] FAIL %s.rdWr: observed rd=%b wr=%b expected not both", tag, rd, wr);
  endtask

  task automatic stepCycle();
    bit held;
    held = (expPhase == 4) && (int'(opcode) == 0);
    @(posedge clk);
    #1;
    if (!held) expPhase = (expPhase + 1) % 8;
  endtask

  // zMode 0/1 forces the zero flag; 2 randomizes it every cycle.
  task automatic runInstruction(input int op, input int zMode, input string tag);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(op, (zMode == 2) ? int'($urandom_range(0, 1)) : zMode);
      checkOutput(tag);
      stepCycle();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 3'd5;
    zero   = 1'b0;
    #12;
    checkOutput("reset");
    rst_n = 1'b1;

    runInstruction(5, 2, "lda");
    runInstruction(1, 1, "skzZero");
    runInstruction(1, 0, "skzNonZero");
    runInstruction(7, 2, "jmp");
    runInstruction(6, 2, "sto");
    runInstruction(2, 2, "add");
    runInstruction(3, 2, "and");
    runInstruction(4, 2, "xor");
    for (int i = 0; i < 30; i++) begin
      runInstruction(int'($urandom_range(1, 7)), 2, "random");
    end

    for (int c = 0; c < 16 && expPhase != 5; c++) begin
      applyStimulus(5, 0);
      checkOutput("toPhase5");
      stepCycle();
    end
    applyStimulus(5, 1);
    #1;
    rst_n = 1'b0;
    #1;
    expPhase = 0;
    checkOutput("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("postReset");
    end
    for (int c = 0; c < 8 && expPhase != 0; c++) begin
      applyStimulus(5, 0);
      checkOutput("drain");
      stepCycle();
    end

    for (int c = 0; c < 26; c++) begin
      applyStimulus(0, int'($urandom_range(0, 1)));
      checkOutput("halt");
      stepCycle();
    end
    rst_n = 1'b0;
    #1;
    expPhase = 0;
    checkOutput("haltReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5, 0);
    stepCycle();
    checkOutput("afterHalt");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
